// File: rtl/exp_align_pipe.sv
//------------------------------------------------------------------------------
// Module      : exp_align_pipe
// Description : Two-stage FP exponent-difference / significand-alignment unit
//               with valid/ready handshakes; optional EXP_ALIGN_FARCNT_EN adds
//               a saturating far-shift counter output (far_cnt).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exp_align_pipe #(
    parameter int EW    = 5,
    parameter int MW    = 11,
    parameter int GUARD = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW-1:0]       exp_a,
    input  logic [EW-1:0]       exp_b,
    input  logic [MW-1:0]       man_a,
    input  logic [MW-1:0]       man_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW-1:0]       exp_max,
    output logic [EW-1:0]       diff,
    output logic                swap,
    output logic [MW-1:0]       man_big,
    output logic [MW+GUARD-1:0] man_small_sh
`ifdef EXP_ALIGN_FARCNT_EN
    ,
    output logic [15:0]         far_cnt
`endif
);

    localparam int          c_W     = MW + GUARD;
    localparam logic [31:0] c_W_U32 = 32'(c_W);

    logic                s1_valid_q;
    logic [EW-1:0]       s1_exp_max_q;
    logic [EW-1:0]       s1_diff_q;
    logic                s1_swap_q;
    logic [MW-1:0]       s1_man_big_q;
    logic [MW-1:0]       s1_man_small_q;

    logic                s2_valid_q;
    logic [EW-1:0]       s2_exp_max_q;
    logic [EW-1:0]       s2_diff_q;
    logic                s2_swap_q;
    logic [MW-1:0]       s2_man_big_q;
    logic [c_W-1:0]      s2_man_sh_q;

    logic                w_s2_adv;
    logic                w_s2_load;
    logic                w_s1_adv;
    logic                w_accept;

    assign w_s2_adv  = s2_valid_q && out_ready;
    assign w_s2_load = !s2_valid_q || w_s2_adv;
    assign w_s1_adv  = s1_valid_q && w_s2_load;
    assign in_ready  = !s1_valid_q || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    // Compare stage: the borrow of the widened subtraction selects the larger operand
    logic [EW:0]   w_raw;
    logic          w_borrow;
    logic [EW-1:0] w_diff;

    assign w_raw    = {1'b0, exp_a} - {1'b0, exp_b};
    assign w_borrow = w_raw[EW];
    assign w_diff   = w_borrow ? (exp_b - exp_a) : w_raw[EW-1:0];

    // Align stage
    logic [c_W-1:0] w_ext;
    logic [c_W-1:0] w_sh;
    logic [c_W-1:0] w_mask;
    logic           w_lost;
    logic           w_s1_far;
    logic [c_W-1:0] w_aligned;

    assign w_ext     = {s1_man_small_q, {GUARD{1'b0}}};
    assign w_sh      = w_ext >> s1_diff_q;
    assign w_mask    = ~({c_W{1'b1}} << s1_diff_q);
    assign w_lost    = |(w_ext & w_mask);
    // Shift amounts at or beyond the full width collapse everything into sticky
    assign w_s1_far  = 32'(s1_diff_q) >= c_W_U32;
    assign w_aligned = w_s1_far ? {{(c_W-1){1'b0}}, |s1_man_small_q}
                                : {w_sh[c_W-1:1], w_sh[0] | w_lost};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_exp_max_q   <= '0;
            s1_diff_q      <= '0;
            s1_swap_q      <= 1'b0;
            s1_man_big_q   <= '0;
            s1_man_small_q <= '0;
        end else begin
            if (w_accept) begin
                s1_valid_q     <= 1'b1;
                s1_exp_max_q   <= w_borrow ? exp_b : exp_a;
                s1_diff_q      <= w_diff;
                s1_swap_q      <= w_borrow;
                s1_man_big_q   <= w_borrow ? man_b : man_a;
                s1_man_small_q <= w_borrow ? man_a : man_b;
            end else if (w_s1_adv) begin
                s1_valid_q     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_exp_max_q <= '0;
            s2_diff_q    <= '0;
            s2_swap_q    <= 1'b0;
            s2_man_big_q <= '0;
            s2_man_sh_q  <= '0;
        end else if (w_s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_max_q <= s1_exp_max_q;
                s2_diff_q    <= s1_diff_q;
                s2_swap_q    <= s1_swap_q;
                s2_man_big_q <= s1_man_big_q;
                s2_man_sh_q  <= w_aligned;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign exp_max      = s2_exp_max_q;
    assign diff         = s2_diff_q;
    assign swap         = s2_swap_q;
    assign man_big      = s2_man_big_q;
    assign man_small_sh = s2_man_sh_q;

`ifdef EXP_ALIGN_FARCNT_EN
    logic [15:0] far_cnt_q;
    logic        w_s2_far;

    assign w_s2_far = 32'(s2_diff_q) >= c_W_U32;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            far_cnt_q <= '0;
        end else if (w_s2_adv && w_s2_far && (far_cnt_q != 16'hFFFF)) begin
            far_cnt_q <= far_cnt_q + 16'd1;
        end
    end

    assign far_cnt = far_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exp_align_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_exp_align_pipe
// Description : Scoreboard testbench for exp_align_pipe (directed + random).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_exp_align_pipe;

    localparam int EW    = 5;
    localparam int MW    = 11;
    localparam int GUARD = 3;
    localparam int W     = MW + GUARD;

    typedef struct {
        logic [EW-1:0] emax;
        logic [EW-1:0] dif;
        logic          sw;
        logic [MW-1:0] mb;
        logic [W-1:0]  ms;
        bit            lat;
        int            acyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] exp_a;
    logic [EW-1:0] exp_b;
    logic [MW-1:0] man_a;
    logic [MW-1:0] man_b;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] exp_max;
    logic [EW-1:0] diff;
    logic          swap;
    logic [MW-1:0] man_big;
    logic [W-1:0]  man_small_sh;
`ifdef EXP_ALIGN_FARCNT_EN
    logic [15:0]   far_cnt;
`endif

    exp_align_pipe #(.EW(EW), .MW(MW), .GUARD(GUARD)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exp_a        (exp_a),
        .exp_b        (exp_b),
        .man_a        (man_a),
        .man_b        (man_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .exp_max      (exp_max),
        .diff         (diff),
        .swap         (swap),
        .man_big      (man_big),
        .man_small_sh (man_small_sh)
`ifdef EXP_ALIGN_FARCNT_EN
        ,
        .far_cnt      (far_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc   = 0;
    int   far_model = 0;
    exp_t sb[$];
    int   pop_cyc[$];
    exp_t mon_e;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Bit-by-bit reference: result bit i takes ext bit i+d; everything below d is sticky
    function automatic logic [W-1:0] align_model(input logic [MW-1:0] m, input int d);
        logic [W-1:0] e;
        logic [W-1:0] r;
        logic         st;
        e  = {m, {GUARD{1'b0}}};
        r  = '0;
        st = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i + d < W) r[i] = e[i + d];
            if (i < d)     st   = st | e[i];
        end
        r[0] = r[0] | st;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                        input logic [MW-1:0] ma, input logic [MW-1:0] mb, input bit lat);
        exp_t e;
        bit   acc;
        int   d;
        e.sw   = (eb > ea);
        e.emax = e.sw ? eb : ea;
        d      = e.sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        e.dif  = d[EW-1:0];
        e.mb   = e.sw ? mb : ma;
        e.ms   = align_model(e.sw ? ma : mb, d);
        e.lat  = lat;
        exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.acyc = cyc;
                sb.push_back(e);
                n_acc++;
            end
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        check_val("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb[0];
                check_val(out_ready ? "exp_max" : "hold_exp_max", exp_max, mon_e.emax);
                check_val(out_ready ? "diff" : "hold_diff", diff, mon_e.dif);
                check_val(out_ready ? "swap" : "hold_swap", swap, mon_e.sw);
                check_val(out_ready ? "man_big" : "hold_man_big", man_big, mon_e.mb);
                check_val(out_ready ? "man_small_sh" : "hold_man_small_sh", man_small_sh, mon_e.ms);
                if (out_ready) begin
                    if (mon_e.lat) check_val("latency", cyc - mon_e.acyc, 32'd2);
`ifdef EXP_ALIGN_FARCNT_EN
                    check_val("far_cnt", far_cnt, far_model);
`endif
                    if (int'(mon_e.dif) >= W) far_model++;
                    void'(sb.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
        #12;
        check_val("rst_out_valid", out_valid, 32'd0);
        check_val("rst_in_ready", in_ready, 32'd1);
        check_val("rst_exp_max", exp_max, 32'd0);
        check_val("rst_diff", diff, 32'd0);
        check_val("rst_swap", swap, 32'd0);
        check_val("rst_man_big", man_big, 32'd0);
        check_val("rst_man_small_sh", man_small_sh, 32'd0);
`ifdef EXP_ALIGN_FARCNT_EN
        check_val("rst_far_cnt", far_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back to back
        send(5'd15, 5'd12, 11'h400, 11'h600, 1'b1);
        send(5'd10, 5'd17, 11'h7FF, 11'h500, 1'b1);
        send(5'd30, 5'd2,  11'h000, 11'h400, 1'b1);
        send(5'd30, 5'd2,  11'h000, 11'h000, 1'b1);
        send(5'd9,  5'd9,  11'h123, 11'h455, 1'b1);
        send(5'd0,  5'd31, 11'h7FF, 11'h001, 1'b1);
        send(5'd14, 5'd0,  11'h400, 11'h7FF, 1'b1);
        send(5'd13, 5'd0,  11'h400, 11'h7FF, 1'b1);
        wait_drain();
        check_val("model_basic", align_model(11'h600, 3), 32'h0600);
        check_val("model_sticky", align_model(11'h7FF, 7), 32'h007F);
        check_val("model_equal", align_model(11'h455, 0), 32'h22A8);

        // Backpressure: two accepts fill the pipe, the third waits
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(5'd20, 5'd18, 11'h401, 11'h7F3, 1'b0);
                send(5'd3,  5'd8,  11'h5A5, 11'h6C3, 1'b0);
                send(5'd11, 5'd11, 11'h7FF, 11'h7FF, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check_val("bp_in_ready", in_ready, 32'd0);
                check_val("bp_accepts", n_acc, 32'd2);
                check_val("bp_out_valid", out_valid, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check_val("bp_rate_a", pop_cyc[$] - pop_cyc[$-1], 32'd1);
        check_val("bp_rate_b", pop_cyc[$-1] - pop_cyc[$-2], 32'd1);

        // Random traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 24; k++)
                    send(EW'($urandom_range(0, 31)), EW'($urandom_range(0, 31)),
                         MW'($urandom_range(0, 2047)), MW'($urandom_range(0, 2047)), 1'b0);
            end
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(5'd7, 5'd1, 11'h432, 11'h654, 1'b0);
        send(5'd2, 5'd9, 11'h765, 11'h321, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 32'd0);
        check_val("mid_rst_diff", diff, 32'd0);
        check_val("mid_rst_exp_max", exp_max, 32'd0);
        check_val("mid_rst_man_big", man_big, 32'd0);
        check_val("mid_rst_man_small_sh", man_small_sh, 32'd0);
        check_val("mid_rst_in_ready", in_ready, 32'd1);
        sb.delete();
        far_model = 0;
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(5'd15, 5'd12, 11'h400, 11'h600, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exp_align_pipe.md
Name: exp_align_pipe

Overview:
- Pipelined, parametrised exponent-difference and mantissa-alignment unit for the FP adder/subtractor datapath.
- Takes two (exponent, significand) operand pairs and computes the magnitude of the exponent difference and which operand is larger.
- Right-shifts the smaller significand by that difference, with guard bits and a sticky bit.
- Sits between operand unpacking and the significand adder; uses valid/ready handshakes on both sides.

Parameters:
- EW, 5, exponent width in bits.
- MW, 11, significand width in bits, including the hidden bit.
- GUARD, 3, number of extra low-order alignment bits appended below the significand. Must be ≥1; bit 0 is the sticky bit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input operands valid.
- in_ready  out  1  unit can accept operands this cycle.
- exp_a  in  EW  exponent of operand A, unsigned.
- exp_b  in  EW  exponent of operand B, unsigned.
- man_a  in  MW  significand of operand A.
- man_b  in  MW  significand of operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- exp_max  out  EW  the larger exponent.
- diff  out  EW  |exp_a − exp_b|.
- swap  out  1  1 when exp_b > exp_a.
- man_big  out  MW  significand of the larger-exponent operand.
- man_small_sh  out  MW+GUARD  aligned smaller significand; bit 0 is sticky.

Behaviour:
- Reset values (rst_n low, applied asynchronously):
  - Both stage valid flags = 0, so out_valid = 0.
  - exp_max, diff, swap, man_big, man_small_sh all = 0.
  - in_ready is combinational from the stage flags, so it reads 1 while reset is held.
- Pipeline: two register stages, S1 and S2. Latency is 2 cycles from the in_valid&&in_ready edge to out_valid. Throughput is 1 per cycle when out_ready is held high.
- S1 (compare/subtract):
  - raw = {0,exp_a} − {0,exp_b}, computed in EW+1 bits; borrow = raw[EW].
  - swap = borrow.
  - diff = borrow ? (exp_b − exp_a) : raw[EW-1:0].
  - exp_max = borrow ? exp_b : exp_a.
  - S1 registers diff, swap and exp_max, plus the big and small significands selected by swap.
  - Equal exponents: diff = 0, swap = 0.
- S2 (align):
  - ext = {man_small, GUARD zeros}, MW+GUARD bits wide.
  - sh = ext >> diff; lost = OR of the bits of ext shifted out.
  - man_small_sh = {sh[MW+GUARD-1:1], sh[0] | lost}.
  - If diff ≥ MW+GUARD: man_small_sh = {zeros, |man_small}. There is no wrap or modulo on the shift amount.
  - man_big, exp_max, diff and swap pass through unchanged.
- Handshake:
  - s2_adv = s2_valid && out_ready.
  - S2 loads when !s2_valid || s2_adv.
  - S1 advances into S2 under that same condition.
  - in_ready = !s1_valid || (S1 advances this cycle).
  - Output fields are stable while out_valid && !out_ready.
  - Ordering is preserved: no drops, no duplicates.
- Simultaneous events: an accept into S1 and an advance of S1 into S2 in the same cycle are legal; both happen and no bubble is inserted.
- Capacity: 2 transactions in flight. When full with out_ready low, in_ready = 0.
- Reset mid-operation flushes both stages; in-flight transactions are discarded.
- No other state is kept; there is no FSM beyond the two stage valid flags.

Optional Feature:
- Macro: EXP_ALIGN_FARCNT_EN.
- When defined:
  - Adds output port far_cnt, 16 bits wide.
  - far_cnt is a saturating count of transactions leaving S2 (s2_adv) with diff ≥ MW+GUARD.
  - It resets to 0 and holds at 0xFFFF once reached.
- When undefined: the port and counter are absent; the datapath is identical.

Test Plan:
- Defaults used throughout: EW=5, MW=11, GUARD=3.
- Basic alignment: exp_a=15, exp_b=12, man_a=0x400, man_b=0x600, out_ready=1 → 2 cycles later: exp_max=15, diff=3, swap=0, man_big=0x400, man_small_sh=0x0600.
- Swap with sticky: exp_a=10, exp_b=17, man_a=0x7FF, man_b=0x500 → exp_max=17, diff=7, swap=1, man_big=0x500, man_small_sh=0x007F. Lost bits 0x78 ≠ 0, so bit 0 = 1.
- Far shift: exp_a=30, exp_b=2, man_b=0x400 → diff=28, man_small_sh=0x0001. With man_b=0: man_small_sh=0x0000. With EXP_ALIGN_FARCNT_EN, far_cnt increments 0→1→2.
- Equal exponents: exp_a=exp_b=9, man_b=0x455 → diff=0, swap=0, man_small_sh=0x22A8.
- Backpressure: 3 back-to-back inputs with out_ready=0 for 5 cycles → in_ready drops after 2 accepts and outputs hold stable. Raise out_ready → all 3 results emerge in order, 1 per cycle.
- Reset mid-operation: both stages valid, pulse rst_n low between clock edges → out_valid = 0 immediately, outputs = 0, and the first accept after release yields a result 2 cycles later.
